ahb3_bootrom_bridge: RTL and testbench



---
 rtl/ahb3_bootrom_bridge.sv | 147 ++++++++++++++
 tb/tb_ahb3_bootrom_bridge.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3_bootrom_bridge.sv
// AHB3 slave front end for a combinational boot ROM word array.
// Optional: AHB3_BOOTROM_WRITE_IGNORE_EN completes legal writes with OKAY.
module ahb3_bootrom_bridge #(
  parameter int PLEN        = 32,
  parameter int XLEN        = 32,
  parameter int ROM_AW      = 6,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ahb3_hsel_i,
  input  logic [PLEN-1:0]   ahb3_haddr_i,
  input  logic [XLEN-1:0]   ahb3_hwdata_i,
  input  logic              ahb3_hwrite_i,
  input  logic [2:0]        ahb3_hsize_i,
  input  logic [2:0]        ahb3_hburst_i,
  input  logic [3:0]        ahb3_hprot_i,
  input  logic [1:0]        ahb3_htrans_i,
  input  logic              ahb3_hmastlock_i,
  input  logic              ahb3_hready_i,
  output logic [XLEN-1:0]   ahb3_hrdata_o,
  output logic              ahb3_hreadyout_o,
  output logic              ahb3_hresp_o,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [XLEN-1:0]   rom_data_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       hwrite_q;
  logic [2:0] hsize_q;

  logic accept;
  logic bad_size;
  logic bad_align;
  logic wr_err;
  logic wr_skip;
  logic xfer_err;
  logic load_addr;
  logic load_data;
  logic unused_ok;

  assign accept = ahb3_hsel_i & ahb3_hready_i
                & ahb3_htrans_i[1];

  assign bad_size = ahb3_hsize_i > 3'b010;

  always_comb begin
    bad_align = 1'b0;
    unique case (ahb3_hsize_i)
      3'b001:  bad_align = ahb3_haddr_i[0];
      3'b010:  bad_align = |ahb3_haddr_i[1:0];
      default: bad_align = 1'b0;
    endcase
  end

`ifdef AHB3_BOOTROM_WRITE_IGNORE_EN
  assign wr_err  = 1'b0;
  assign wr_skip = ahb3_hwrite_i & ~bad_size
                 & ~bad_align;
`else
  assign wr_err  = ahb3_hwrite_i;
  assign wr_skip = 1'b0;
`endif

  assign xfer_err = bad_size | bad_align | wr_err;

  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    load_addr        = 1'b0;
    load_data        = 1'b0;
    ahb3_hreadyout_o = 1'b1;
    ahb3_hresp_o     = 1'b0;
    case (state)
      S_IDLE, S_DATA, S_ERR2: begin
        // Pipelined accept: a new address phase may
        // overlap the last cycle of the previous one.
        ahb3_hresp_o = (state == S_ERR2);
        state_nxt    = S_IDLE;
        if (accept && !wr_skip) begin
          load_addr = 1'b1;
          if (xfer_err) begin
            state_nxt = S_ERR1;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        ahb3_hreadyout_o = 1'b0;
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          load_data = 1'b1;
          state_nxt = S_DATA;
        end
      end
      S_ERR1: begin
        ahb3_hreadyout_o = 1'b0;
        ahb3_hresp_o     = 1'b1;
        state_nxt        = S_ERR2;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      cnt           <= 4'd0;
      rom_addr_o    <= '0;
      ahb3_hrdata_o <= '0;
      hwrite_q      <= 1'b0;
      hsize_q       <= 3'b000;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load_addr) begin
        rom_addr_o <= ahb3_haddr_i[ROM_AW+1:2];
        hwrite_q   <= ahb3_hwrite_i;
        hsize_q    <= ahb3_hsize_i;
      end
      if (load_data) begin
        ahb3_hrdata_o <= rom_data_i;
      end
    end
  end

  assign unused_ok = ^{ahb3_hwdata_i, ahb3_hburst_i,
                       ahb3_hprot_i, ahb3_hmastlock_i,
                       ahb3_haddr_i[PLEN-1:ROM_AW+2],
                       ahb3_htrans_i[0], hwrite_q,
                       hsize_q};

endmodule

// File: tb/tb_ahb3_bootrom_bridge.sv
// Directed bench for ahb3_bootrom_bridge.
// Two instances: WAIT_STATES=0 and WAIT_STATES=3.
module tb_ahb3_bootrom_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'b010;
  logic [1:0]  htrans = 2'b00;
  logic        hr_block = 1'b0;
  logic        use3 = 1'b0;
  logic        hready;

  logic [31:0] rdata0, rdata3, rom0, rom3;
  logic        ro0, ro3, resp0, resp3;
  logic [5:0]  ra0, ra3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [5:0] i);
    if (i == 6'd2) return 32'hDEADBEEF;
    return 32'hC000_0000 | 32'(i);
  endfunction

  assign rom0   = rom_word(ra0);
  assign rom3   = rom_word(ra3);
  assign hready = hr_block ? 1'b0 : (use3 ? ro3 : ro0);

  ahb3_bootrom_bridge #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst),
    .ahb3_hsel_i(hsel), .ahb3_haddr_i(haddr),
    .ahb3_hwdata_i(32'h1234_5678),
    .ahb3_hwrite_i(hwrite), .ahb3_hsize_i(hsize),
    .ahb3_hburst_i(3'b000), .ahb3_hprot_i(4'b0011),
    .ahb3_htrans_i(htrans), .ahb3_hmastlock_i(1'b0),
    .ahb3_hready_i(hready),
    .ahb3_hrdata_o(rdata0), .ahb3_hreadyout_o(ro0),
    .ahb3_hresp_o(resp0), .rom_addr_o(ra0),
    .rom_data_i(rom0)
  );

  ahb3_bootrom_bridge #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst),
    .ahb3_hsel_i(hsel), .ahb3_haddr_i(haddr),
    .ahb3_hwdata_i(32'h1234_5678),
    .ahb3_hwrite_i(hwrite), .ahb3_hsize_i(hsize),
    .ahb3_hburst_i(3'b000), .ahb3_hprot_i(4'b0011),
    .ahb3_htrans_i(htrans), .ahb3_hmastlock_i(1'b0),
    .ahb3_hready_i(hready),
    .ahb3_hrdata_o(rdata3), .ahb3_hreadyout_o(ro3),
    .ahb3_hresp_o(resp3), .rom_addr_o(ra3),
    .rom_data_i(rom3)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic s, input logic [31:0] a,
                     input logic w, input logic [2:0] sz,
                     input logic [1:0] tr);
    hsel = s; haddr = a; hwrite = w;
    hsize = sz; htrans = tr;
  endtask

  task automatic idle();
    put(1'b0, 32'h0, 1'b0, 3'b010, 2'b00);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    cyc(); cyc();
    checks++;
    if (ro0 !== 1'b1 || resp0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp0 got ro=%b resp=%b want 1/0", ro0, resp0);
    end
    checks++;
    if (rdata0 !== 32'h0 || ra0 !== 6'd0) begin
      errors++;
      $display("FAIL reset_data0 got %h/%0d want 0/0", rdata0, ra0);
    end
    checks++;
    if (ro3 !== 1'b1 || resp3 !== 1'b0 || rdata3 !== 32'h0) begin
      errors++;
      $display("FAIL reset_dut3 got ro=%b resp=%b d=%h", ro3, resp3, rdata3);
    end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_read();
    put(1'b1, 32'h0000_0008, 1'b0, 3'b010, 2'b10);
    cyc();
    idle();
    checks++;
    if (ra0 !== 6'd2) begin
      errors++;
      $display("FAIL read_addr got %0d want 2", ra0);
    end
    checks++;
    if (ro0 !== 1'b0 || resp0 !== 1'b0) begin
      errors++;
      $display("FAIL read_wait got ro=%b resp=%b want 0/0", ro0, resp0);
    end
    cyc();
    checks++;
    if (ro0 !== 1'b1 || resp0 !== 1'b0) begin
      errors++;
      $display("FAIL read_done got ro=%b resp=%b want 1/0", ro0, resp0);
    end
    checks++;
    if (rdata0 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_data got %h want deadbeef", rdata0);
    end
    cyc();
  endtask

  task automatic test_write();
    put(1'b1, 32'h0, 1'b1, 3'b010, 2'b10);
    cyc();
    idle();
`ifdef AHB3_BOOTROM_WRITE_IGNORE_EN
    checks++;
    if (ro0 !== 1'b1 || resp0 !== 1'b0) begin
      errors++;
      $display("FAIL write_ok got ro=%b resp=%b want 1/0", ro0, resp0);
    end
    checks++;
    if (ra0 !== 6'd2 || rdata0 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_keep got %0d/%h want 2/deadbeef", ra0, rdata0);
    end
`else
    checks++;
    if (ro0 !== 1'b0 || resp0 !== 1'b1) begin
      errors++;
      $display("FAIL write_err1 got ro=%b resp=%b want 0/1", ro0, resp0);
    end
    cyc();
    checks++;
    if (ro0 !== 1'b1 || resp0 !== 1'b1) begin
      errors++;
      $display("FAIL write_err2 got ro=%b resp=%b want 1/1", ro0, resp0);
    end
    checks++;
    if (rdata0 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_data got %h want deadbeef", rdata0);
    end
`endif
    cyc();
    checks++;
    if (ro0 !== 1'b1 || resp0 !== 1'b0) begin
      errors++;
      $display("FAIL write_after got ro=%b resp=%b want 1/0", ro0, resp0);
    end
  endtask

  task automatic test_errors();
    put(1'b1, 32'h0, 1'b0, 3'b011, 2'b10);
    cyc();
    idle();
    checks++;
    if (ro0 !== 1'b0 || resp0 !== 1'b1) begin
      errors++;
      $display("FAIL size_err1 got ro=%b resp=%b want 0/1", ro0, resp0);
    end
    cyc();
    checks++;
    if (ro0 !== 1'b1 || resp0 !== 1'b1) begin
      errors++;
      $display("FAIL size_err2 got ro=%b resp=%b want 1/1", ro0, resp0);
    end
    cyc();
    put(1'b1, 32'h2, 1'b0, 3'b010, 2'b10);
    cyc();
    put(1'b1, 32'h4, 1'b0, 3'b010, 2'b10);
    checks++;
    if (ro0 !== 1'b0 || resp0 !== 1'b1) begin
      errors++;
      $display("FAIL align_err1 got ro=%b resp=%b want 0/1", ro0, resp0);
    end
    cyc();
    checks++;
    if (ro0 !== 1'b1 || resp0 !== 1'b1) begin
      errors++;
      $display("FAIL align_err2 got ro=%b resp=%b want 1/1", ro0, resp0);
    end
    cyc();
    idle();
    checks++;
    if (ro0 !== 1'b0 || resp0 !== 1'b0 || ra0 !== 6'd1) begin
      errors++;
      $display("FAIL pipe_wait got ro=%b resp=%b a=%0d want 0/0/1", ro0, resp0, ra0);
    end
    cyc();
    checks++;
    if (ro0 !== 1'b1 || resp0 !== 1'b0 || rdata0 !== 32'hC000_0001) begin
      errors++;
      $display("FAIL pipe_data got ro=%b resp=%b d=%h want 1/0/c0000001", ro0, resp0, rdata0);
    end
    cyc();
    put(1'b1, 32'h1, 1'b0, 3'b001, 2'b10);
    cyc();
    idle();
    checks++;
    if (ro0 !== 1'b0 || resp0 !== 1'b1) begin
      errors++;
      $display("FAIL half_err got ro=%b resp=%b want 0/1", ro0, resp0);
    end
    cyc(); cyc();
  endtask

  task automatic test_wrap_busy();
    put(1'b1, 32'h0000_0100, 1'b0, 3'b010, 2'b10);
    cyc();
    idle();
    checks++;
    if (ra0 !== 6'd0) begin
      errors++;
      $display("FAIL wrap_addr got %0d want 0", ra0);
    end
    cyc();
    checks++;
    if (rdata0 !== 32'hC000_0000 || resp0 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_data got %h resp=%b want c0000000/0", rdata0, resp0);
    end
    cyc();
    put(1'b1, 32'h0000_000C, 1'b0, 3'b010, 2'b01);
    cyc();
    checks++;
    if (ro0 !== 1'b1 || resp0 !== 1'b0 || ra0 !== 6'd0) begin
      errors++;
      $display("FAIL busy got ro=%b resp=%b a=%0d want 1/0/0", ro0, resp0, ra0);
    end
    cyc();
    checks++;
    if (ro0 !== 1'b1 || rdata0 !== 32'hC000_0000) begin
      errors++;
      $display("FAIL busy_hold got ro=%b d=%h want 1/c0000000", ro0, rdata0);
    end
    put(1'b0, 32'h0000_000C, 1'b0, 3'b010, 2'b10);
    cyc();
    checks++;
    if (ro0 !== 1'b1 || ra0 !== 6'd0) begin
      errors++;
      $display("FAIL nosel got ro=%b a=%0d want 1/0", ro0, ra0);
    end
    hr_block = 1'b1;
    put(1'b1, 32'h0000_000C, 1'b0, 3'b010, 2'b10);
    cyc();
    hr_block = 1'b0;
    idle();
    checks++;
    if (ro0 !== 1'b1 || ra0 !== 6'd0) begin
      errors++;
      $display("FAIL hready_low got ro=%b a=%0d want 1/0", ro0, ra0);
    end
    put(1'b1, 32'h0000_000E, 1'b0, 3'b000, 2'b10);
    cyc();
    idle();
    cyc();
    checks++;
    if (rdata0 !== 32'hC000_0003 || resp0 !== 1'b0) begin
      errors++;
      $display("FAIL byte_read got %h resp=%b want c0000003/0", rdata0, resp0);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [3];
    int n;
    exp[0] = 32'hC000_0000;
    exp[1] = 32'hC000_0001;
    exp[2] = 32'hDEADBEEF;
    idle();
    repeat (6) cyc();
    use3 = 1'b1;
    put(1'b1, 32'h0, 1'b0, 3'b010, 2'b10);
    cyc();
    put(1'b1, 32'h4, 1'b0, 3'b010, 2'b11);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (ro3 == 1'b0 && n < 20) begin
        n++;
        cyc();
      end
      checks++;
      if (n !== 4) begin
        errors++;
        $display("FAIL b2b_wait%0d got %0d want 4", k, n);
      end
      checks++;
      if (rdata3 !== exp[k] || resp3 !== 1'b0) begin
        errors++;
        $display("FAIL b2b_data%0d got %h resp=%b want %h/0", k, rdata3, resp3, exp[k]);
      end
      cyc();
      if (k == 0) put(1'b1, 32'h8, 1'b0, 3'b010, 2'b11);
      else idle();
    end
    use3 = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    put(1'b1, 32'h0000_0004, 1'b0, 3'b010, 2'b10);
    cyc();
    idle();
    rst = 1'b0;
    cyc(); cyc();
    checks++;
    if (ro0 !== 1'b1 || resp0 !== 1'b0) begin
      errors++;
      $display("FAIL rmid_resp got ro=%b resp=%b want 1/0", ro0, resp0);
    end
    checks++;
    if (rdata0 !== 32'h0 || ra0 !== 6'd0) begin
      errors++;
      $display("FAIL rmid_data got %h/%0d want 0/0", rdata0, ra0);
    end
    rst = 1'b1;
    cyc();
    checks++;
    if (ro0 !== 1'b1 || resp0 !== 1'b0 || rdata0 !== 32'h0) begin
      errors++;
      $display("FAIL rmid_after got ro=%b resp=%b d=%h", ro0, resp0, rdata0);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_errors();
    test_wrap_busy();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
